// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low requests and registered active-low grants.
// Optional hogging watchdog is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] bus_owner,
  output logic       bus_busy,
  output logic       arb_timeout
);

  // Handshake: a master holds req_ low for as long as it wants the bus; its
  // grnt_ goes low one edge after req_ is sampled low and stays low until the
  // edge that samples req_ high (or a watchdog revoke). Only one grnt_ is low.

  typedef enum logic {IDLE, OWNED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  grnt_q, grnt_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  req;
  logic [2:0]  pick_any, pick_other;
  logic        wd_expire;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // Returns {found, index}; candidates are from+1, from+2, from+3 and, when
  // incl_from is set, from itself last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from,
                                         input logic incl_from);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (!res[2] && r[idx] && (incl_from || k != 4)) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick_any   = rr_pick(req, owner_q, 1'b1);
  assign pick_other = rr_pick(req, owner_q, 1'b0);

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;

  assign wd_expire = (state_q == OWNED) && (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Counter restarts whenever ownership changes or the bus is idle, and only
  // advances while some other master is waiting.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q != OWNED || state_d != OWNED || owner_d != owner_q) wd_cnt_d = 16'd0;
    else if (pick_other[2]) wd_cnt_d = wd_cnt_q + 16'd1;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any[2]) begin
          state_d = OWNED;
          owner_d = pick_any[1:0];
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          // Release wins over a simultaneous watchdog expiry.
          if (pick_other[2]) owner_d = pick_other[1:0];
          else               state_d = IDLE;
        end else if (wd_expire && pick_other[2]) begin
          owner_d   = pick_other[1:0];
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    grnt_d = (state_d == OWNED) ? ~(4'b0001 << owner_d) : 4'b1111;
    busy_d = (state_d == OWNED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 2'd3;
      grnt_q    <= 4'b1111;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      grnt_q    <= grnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_cnt_q  <= wd_cnt_d;
`endif
    end
  end

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_q;
  assign bus_owner   = owner_q;
  assign bus_busy    = busy_q;
  assign arb_timeout = timeout_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Four-master round-robin arbiter for the shared system bus. It grants bus ownership to one master at a time, and that master then drives address and strobes that the address decoder turns into slave chip selects. Ownership is held until the owner releases its request. An optional watchdog forcibly revokes ownership from a master that hogs the bus while others wait.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 256: owned cycles with competing requests before forced revoke. Range 2..65535; counter is 16 bits. Used only when the watchdog is compiled in.

Ports:
- clk  input  1  bus clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- m0_req_ .. m3_req_  input  1 each  bus request from master n, active-low
- m0_grnt_ .. m3_grnt_  output  1 each  bus grant to master n, active-low, registered
- bus_owner  output  2  index of the current or last owner, registered
- bus_busy  output  1  high while any grant is asserted
- arb_timeout  output  1  one-cycle pulse when a grant is forcibly revoked

## Operation
- FSM states:
  - IDLE: no grant asserted.
  - OWNED: exactly one grant asserted, the one selected by bus_owner.
- Round-robin search: candidates are checked in order owner+1, owner+2, owner+3, owner (mod 4), using the current bus_owner.
- IDLE -> OWNED:
  - Condition: any req_ is low at a clock edge.
  - Grant goes to the first requester in the round-robin search.
  - bus_owner updates to that master.
- OWNED, owner's req_ still low: hold; grants do not change.
- OWNED, owner's req_ high (released):
  - If another master requests: hand over directly to the next requester, searching from owner+1. The handover takes one edge with no idle gap.
  - If no other master requests: go to IDLE and deassert all grants. bus_owner keeps its value.
- The search excludes the releasing owner. A master that deasserts and reasserts req_ in the same cycle therefore loses priority if anyone else is waiting.
- Invariants:
  - At most one mN_grnt_ is low in any cycle.
  - bus_busy = (state == OWNED).
- A grant is never withdrawn while the owner still requests, except by a watchdog revoke.

## Timing
- Reset values, applied immediately on reset high, independent of clk:
  - state = IDLE
  - all mN_grnt_ = 1
  - bus_owner = 3, so the first search starts at master 0
  - bus_busy = 0
  - arb_timeout = 0
  - watchdog counter = 0
- Grant latency: req_ sampled low at edge k gives grnt_ low after edge k, i.e. one cycle.
- Release latency: owner req_ high at edge k gives that grant high after edge k. Any new grant appears at the same edge.
- Reset asserted mid-ownership: all grants drop asynchronously. After reset releases, arbitration restarts from master 0.
- All four requesting at once from IDLE after reset: master 0 wins, then 1, 2, 3 as each one releases.
- Inputs are assumed synchronous to clk; no synchronizers are included.

## Configuration
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every ownership change and while in IDLE.
  - It increments each OWNED cycle in which at least one non-owner req_ is low, and holds otherwise.
  - When the counter equals TIMEOUT_CYCLES-1 at an edge and the owner still requests:
    - the grant moves to the next non-owner requester in round-robin order;
    - arb_timeout pulses high for exactly that cycle;
    - the counter clears.
  - The revoked master must re-arbitrate like any other requester.
  - If the owner releases on the same edge the watchdog expires, the release takes precedence and arb_timeout stays low.
- Undefined: no counter is built, arb_timeout is tied 0, and ownership is held indefinitely.

## Test plan
- Reset with all req_ high → all grnt_ = 1, bus_busy = 0, bus_owner = 3. Assert reset mid-ownership → grants drop without waiting for a clock edge.
- m2_req_ low at edge 5 → m2_grnt_ low after edge 5; bus_owner = 2. Release at edge 9 → IDLE after edge 9; bus_owner stays 2.
- All four req_ low and held; each owner releases after 3 cycles → grant order 0, 1, 2, 3, with back-to-back handover and no idle cycle between owners.
- Owner 1 holds while m0_req_ and m3_req_ are low; owner 1 releases → m3 is granted next (searches 2, 3 in order), not m0.
- BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8: m0 owns, m1 requests continuously → after 8 competing cycles, m1_grnt_ low, m0_grnt_ high, and arb_timeout pulses for 1 cycle. With m1 idle, m0 holds 100 cycles with no revoke.
- BUS_ARB_TIMEOUT_EN, owner releases on the same edge the counter expires → normal handover, arb_timeout = 0. Build without the macro → arb_timeout constant 0 and m0 holds indefinitely.
